// File: rtl/megaman_buster.sv
// Mega Man buster: three-slot shot pool advanced once per frame tick, with
// edge-triggered firing, cooldown and a combinational pixel hit test.

module megaman_buster_slot #(
  parameter int SHOT_SPEED = 6,
  parameter int SHOT_W     = 8,
  parameter int SHOT_H     = 4
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic       tick,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic       spawn_dir,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       active,
  output logic       hit
);
  localparam logic [10:0] SPEED = 11'(SHOT_SPEED);
  localparam logic [10:0] W     = 11'(SHOT_W);
  localparam logic [10:0] H     = 11'(SHOT_H);

  logic [9:0]  x, y;
  logic        dir;
  logic [10:0] x_ext, y_ext, dx, dy;
  logic        right_out, left_out;

  // 11-bit math so edge tests never wrap
  assign x_ext     = {1'b0, x};
  assign y_ext     = {1'b0, y};
  assign dx        = {1'b0, draw_x};
  assign dy        = {1'b0, draw_y};
  assign right_out = (x_ext + SPEED + W) > 11'd639;
  assign left_out  = x_ext < SPEED;

  assign hit = active && (dx >= x_ext) && (dx <= x_ext + W - 11'd1)
                      && (dy >= y_ext) && (dy <= y_ext + H - 11'd1);

  always_ff @(posedge Clk) begin
    if (RESET) begin
      active <= 1'b0;
      x      <= '0;
      y      <= '0;
      dir    <= 1'b0;
    end else if (tick) begin
      if (spawn) begin
        active <= 1'b1;
        x      <= spawn_x;
        y      <= spawn_y;
        dir    <= spawn_dir;
      end else if (active) begin
        if (dir) begin
          if (right_out) active <= 1'b0;
          else           x      <= x + SPEED[9:0];
        end else begin
          if (left_out)  active <= 1'b0;
          else           x      <= x - SPEED[9:0];
        end
      end
    end
  end
endmodule

module megaman_buster #(
  parameter int SHOT_SPEED = 6,
  parameter int COOLDOWN   = 8,
  parameter int SHOT_W     = 8,
  parameter int SHOT_H     = 4
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic       frame_clk,
  input  logic       x_shoot_key,
  input  logic [9:0] Megaman_x_position,
  input  logic [9:0] Megaman_y_position,
  input  logic       last_horizontal,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_shot,
  output logic [2:0] shot_active,
  output logic       shot_fire
);
  localparam int NUM_SLOTS = 3;
  localparam int CW        = $clog2(COOLDOWN + 2);

  logic                 frame_clk_delayed, tick, key_prev;
  logic [CW-1:0]        cooldown;
  logic [NUM_SLOTS-1:0] active, hit, free, sel;
  logic                 fire_req, spawn;
  logic [9:0]           spawn_x, spawn_y;

  // Allocation looks only at pre-tick flags, so a slot freed this tick waits
  assign free     = ~active;
  assign sel      = free & (~free + 3'd1);
  assign fire_req = x_shoot_key & ~key_prev;
  assign spawn    = tick & fire_req & (cooldown == '0) & (|free);

  assign spawn_y = Megaman_y_position + 10'd26;
  assign spawn_x = last_horizontal ? Megaman_x_position + 10'd60 :
                   (Megaman_x_position < 10'd8) ? 10'd0 : Megaman_x_position - 10'd8;

  always_ff @(posedge Clk) begin
    if (RESET) begin
      frame_clk_delayed <= 1'b0;
      tick              <= 1'b0;
      key_prev          <= 1'b0;
      cooldown          <= '0;
      shot_fire         <= 1'b0;
    end else begin
      frame_clk_delayed <= frame_clk;
      tick              <= frame_clk & ~frame_clk_delayed;
      shot_fire         <= spawn;
      if (tick) begin
        key_prev <= x_shoot_key;
        if (spawn)                 cooldown <= CW'(COOLDOWN);
        else if (cooldown != '0)   cooldown <= cooldown - 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    megaman_buster_slot #(
      .SHOT_SPEED(SHOT_SPEED), .SHOT_W(SHOT_W), .SHOT_H(SHOT_H)
    ) u_slot (
      .Clk      (Clk),
      .RESET    (RESET),
      .tick     (tick),
      .spawn    (spawn & sel[i]),
      .spawn_x  (spawn_x),
      .spawn_y  (spawn_y),
      .spawn_dir(last_horizontal),
      .draw_x   (DrawX),
      .draw_y   (DrawY),
      .active   (active[i]),
      .hit      (hit[i])
    );
  end

  assign is_shot     = |hit;
  assign shot_active = active;
endmodule

// File: tb/tb_megaman_buster.sv
// Bench for megaman_buster: per-tick scoreboard against a small behavioural
// model plus directed position/edge checks.

module tb_megaman_buster;
  localparam int SPEED = 6;
  localparam int SW    = 8;
  localparam int SH    = 4;
  localparam int CD    = 8;

  logic       Clk = 0, RESET = 0, frame_clk = 0, x_shoot_key = 0, last_horizontal = 0;
  logic [9:0] Megaman_x_position = 0, Megaman_y_position = 0, DrawX = 0, DrawY = 0;
  logic       is_shot, shot_fire;
  logic [2:0] shot_active;

  megaman_buster dut (
    .Clk(Clk), .RESET(RESET), .frame_clk(frame_clk), .x_shoot_key(x_shoot_key),
    .Megaman_x_position(Megaman_x_position), .Megaman_y_position(Megaman_y_position),
    .last_horizontal(last_horizontal), .DrawX(DrawX), .DrawY(DrawY),
    .is_shot(is_shot), .shot_active(shot_active), .shot_fire(shot_fire)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0, n_fail = 0, fire_cnt = 0;
  always @(negedge Clk) if (shot_fire === 1'b1) fire_cnt++;

  typedef struct { bit fire; logic [2:0] act; } exp_t;
  exp_t sbq[$];

  int m_x[3], m_y[3];
  bit m_act[3], m_dir[3], m_key;
  int m_cd;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin m_x[i] = 0; m_y[i] = 0; m_act[i] = 0; m_dir[i] = 0; end
    m_key = 0; m_cd = 0; sbq.delete();
  endtask

  task automatic model_step(output exp_t e);
    bit pre[3]; bit fire, spawn; int idx;
    for (int i = 0; i < 3; i++) pre[i] = m_act[i];
    fire  = x_shoot_key && !m_key;
    m_key = x_shoot_key;
    spawn = fire && m_cd == 0 && !(pre[0] && pre[1] && pre[2]);
    for (int i = 0; i < 3; i++)
      if (pre[i]) begin
        if (m_dir[i]) begin
          if (m_x[i] + SPEED + SW > 639) m_act[i] = 0; else m_x[i] += SPEED;
        end else begin
          if (m_x[i] < SPEED) m_act[i] = 0; else m_x[i] -= SPEED;
        end
      end
    if (spawn) begin
      idx = !pre[0] ? 0 : (!pre[1] ? 1 : 2);
      m_act[idx] = 1; m_dir[idx] = last_horizontal;
      m_y[idx] = int'(Megaman_y_position) + 26;
      if (last_horizontal) m_x[idx] = int'(Megaman_x_position) + 60;
      else m_x[idx] = (Megaman_x_position < 8) ? 0 : int'(Megaman_x_position) - 8;
      m_cd = CD;
    end else if (m_cd > 0) m_cd--;
    e.fire = spawn;
    e.act  = {m_act[2], m_act[1], m_act[0]};
  endtask

  function automatic bit model_hit(int dx, int dy);
    bit h = 0;
    for (int i = 0; i < 3; i++)
      if (m_act[i] && dx >= m_x[i] && dx <= m_x[i] + SW - 1 && dy >= m_y[i] && dy <= m_y[i] + SH - 1) h = 1;
    return h;
  endfunction

  task automatic probe(int px, int py, string name);
    bit exp_h;
    if (px < 0 || py < 0 || px > 1023 || py > 1023) return;
    exp_h = model_hit(px, py);
    DrawX = 10'(px); DrawY = 10'(py); #1;
    n_tests++;
    if (is_shot !== exp_h) begin
      n_fail++;
      $display("FAIL %s is_shot at (%0d,%0d): got %b expected %b", name, px, py, is_shot, exp_h);
    end
  endtask

  task automatic check_pt(int px, int py, bit exp_h, string name);
    DrawX = 10'(px); DrawY = 10'(py); #1;
    n_tests++;
    if (is_shot !== exp_h) begin
      n_fail++;
      $display("FAIL %s is_shot at (%0d,%0d): got %b expected %b", name, px, py, is_shot, exp_h);
    end
  endtask

  task automatic check_act(logic [2:0] exp_a, string name);
    n_tests++;
    if (shot_active !== exp_a) begin
      n_fail++;
      $display("FAIL %s shot_active: got %b expected %b", name, shot_active, exp_a);
    end
  endtask

  // One frame tick: push model result, pulse frame_clk, pop and compare.
  task automatic do_tick(output bit fired);
    exp_t e, got;
    int fc0;
    model_step(e);
    sbq.push_back(e);
    fc0 = fire_cnt;
    @(negedge Clk) frame_clk = 1;
    repeat (2) @(posedge Clk);
    #1;
    got.act = shot_active;
    @(negedge Clk) frame_clk = 0;
    repeat (2) @(negedge Clk);
    got.fire = (fire_cnt - fc0) == 1;
    e = sbq.pop_front();
    n_tests++;
    if (got.act !== e.act || (fire_cnt - fc0) != int'(e.fire)) begin
      n_fail++;
      $display("FAIL tick scoreboard: act %b fires %0d expected act %b fires %0d",
               got.act, fire_cnt - fc0, e.act, e.fire);
    end
    for (int i = 0; i < 3; i++)
      if (m_act[i]) begin
        probe(m_x[i], m_y[i], "corner_tl");
        probe(m_x[i] + SW - 1, m_y[i] + SH - 1, "corner_br");
        probe(m_x[i] + SW, m_y[i], "right_of");
        probe(m_x[i] - 1, m_y[i], "left_of");
        probe(m_x[i], m_y[i] + SH, "below");
      end
    fired = e.fire;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    RESET = 1; frame_clk = 0; x_shoot_key = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) RESET = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    check_act(3'b000, "reset_active");
    n_tests++;
    if (shot_fire !== 1'b0) begin n_fail++; $display("FAIL reset_fire: got %b expected 0", shot_fire); end
    check_pt(0, 0, 1'b0, "reset_origin");
  endtask

  task automatic test_basic();
    bit f;
    do_reset();
    Megaman_x_position = 100; Megaman_y_position = 337; last_horizontal = 1; x_shoot_key = 1;
    do_tick(f);
    check_act(3'b001, "basic_spawn");
    check_pt(160, 363, 1'b1, "basic_spawn_pos");
    check_pt(159, 363, 1'b0, "basic_spawn_left");
    do_tick(f);
    check_pt(166, 363, 1'b1, "basic_moved");
    check_pt(165, 363, 1'b0, "basic_moved_left");
  endtask

  task automatic test_left_clamp();
    bit f;
    do_reset();
    Megaman_x_position = 4; Megaman_y_position = 337; last_horizontal = 0; x_shoot_key = 1;
    do_tick(f);
    check_act(3'b001, "clamp_spawn");
    check_pt(0, 363, 1'b1, "clamp_pos");
    do_tick(f);
    check_act(3'b000, "clamp_despawn");
  endtask

  task automatic test_right_edge();
    bit f;
    do_reset();
    Megaman_x_position = 566; Megaman_y_position = 337; last_horizontal = 1; x_shoot_key = 1;
    do_tick(f);
    check_pt(626, 363, 1'b1, "edge626_pos");
    do_tick(f);
    check_act(3'b000, "edge626_gone");
    do_reset();
    Megaman_x_position = 564; x_shoot_key = 1;
    do_tick(f);
    do_tick(f);
    check_act(3'b001, "edge624_moved");
    check_pt(630, 363, 1'b1, "edge630_pos");
    do_tick(f);
    check_act(3'b000, "edge630_gone");
  endtask

  task automatic test_hold_and_cooldown();
    bit f; int n = 0, last = -100;
    do_reset();
    Megaman_x_position = 100; Megaman_y_position = 200; last_horizontal = 1; x_shoot_key = 1;
    for (int t = 0; t < 20; t++) begin do_tick(f); n += int'(f); end
    n_tests++;
    if (n != 1) begin n_fail++; $display("FAIL hold_one_spawn: got %0d spawns expected 1", n); end
    for (int t = 0; t < 40; t++) begin
      x_shoot_key = (t % 4) < 2;
      do_tick(f);
      if (f) begin
        n_tests++;
        if (t - last < CD) begin n_fail++; $display("FAIL cooldown_gap: got %0d ticks expected >= %0d", t - last, CD); end
        last = t;
      end
    end
  endtask

  task automatic test_full_and_despawn();
    bit f, found = 0;
    do_reset();
    Megaman_y_position = 100; last_horizontal = 0;
    Megaman_x_position = 600; x_shoot_key = 1; do_tick(f);
    x_shoot_key = 0; repeat (9) do_tick(f);
    Megaman_x_position = 200; x_shoot_key = 1; do_tick(f);
    x_shoot_key = 0; repeat (9) do_tick(f);
    Megaman_x_position = 600; x_shoot_key = 1; do_tick(f);
    x_shoot_key = 0; repeat (9) do_tick(f);
    check_act(3'b111, "full_three");
    x_shoot_key = 1; do_tick(f);
    n_tests++;
    if (f || shot_active !== 3'b111) begin n_fail++; $display("FAIL full_ignore: act %b expected 111", shot_active); end
    x_shoot_key = 0;
    for (int t = 0; t < 60 && !found; t++) begin
      if (m_act[1] && m_x[1] < SPEED) begin
        found = 1;
        x_shoot_key = 1; do_tick(f);
        check_act(3'b101, "despawn_no_reuse");
        x_shoot_key = 0; do_tick(f);
        x_shoot_key = 1; do_tick(f);
        check_act(3'b111, "slot1_respawn");
      end else do_tick(f);
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL slot1_despawn_seen: got 0 expected 1"); end
  endtask

  task automatic test_reset_midflight();
    bit f; int hits = 0;
    do_reset();
    Megaman_x_position = 300; Megaman_y_position = 200; last_horizontal = 1;
    x_shoot_key = 1; do_tick(f);
    x_shoot_key = 0; repeat (9) do_tick(f);
    x_shoot_key = 1; do_tick(f);
    check_act(3'b011, "mid_two_active");
    @(negedge Clk) RESET = 1;
    @(posedge Clk); #1;
    check_act(3'b000, "mid_reset_clear");
    for (int yy = 0; yy < 480; yy += 2)
      for (int xx = 0; xx < 640; xx += 2) begin
        DrawX = 10'(xx); DrawY = 10'(yy); #1;
        if (is_shot !== 1'b0) hits++;
      end
    n_tests++;
    if (hits != 0) begin n_fail++; $display("FAIL mid_reset_is_shot: got %0d hits expected 0", hits); end
    @(negedge Clk) RESET = 0;
    model_clear();
    do_tick(f);
    check_act(3'b001, "post_reset_spawn");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_left_clamp();
    test_right_edge();
    test_hold_and_cooldown();
    test_full_and_despawn();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/megaman_buster.md
MEGAMAN_BUSTER -- requirements
Module: megaman_buster

Interface
REQ-001 SHALL provide parameters (name, default, meaning): SHOT_SPEED, 6, pixels moved per frame tick; COOLDOWN, 8, frame ticks between shots; SHOT_W, 8, shot width in pixels; SHOT_H, 4, shot height in pixels.
REQ-002 SHALL provide port Clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL provide port RESET, input, 1, reset, synchronous, active-high.
REQ-004 SHALL provide port frame_clk, input, 1, vertical-sync-rate frame clock, sampled in the Clk domain.
REQ-005 SHALL provide port x_shoot_key, input, 1, shoot key level.
REQ-006 SHALL provide ports Megaman_x_position and Megaman_y_position, input, 10 each, top-left corner of the player sprite in pixels.
REQ-007 SHALL provide port last_horizontal, input, 1, facing direction: 1 = right, 0 = left.
REQ-008 SHALL provide ports DrawX and DrawY, input, 10 each, current pixel being drawn.
REQ-009 SHALL provide port is_shot, output, 1, current pixel lies inside an active shot.
REQ-010 SHALL provide port shot_active, output, 3, per-slot active flags.
REQ-011 SHALL provide port shot_fire, output, 1, one-Clk pulse when a shot spawns.

Function
REQ-012 SHALL register frame_clk into frame_clk_delayed and register tick = frame_clk & ~frame_clk_delayed, so tick asserts for exactly one Clk per frame_clk rising edge, 2 Clk after that edge.
REQ-013 SHALL keep 3 slots, each holding active (1 bit), x (10 bits), y (10 bits) and dir (1 bit); slot state SHALL change only in Clk cycles where tick = 1.
REQ-014 SHALL sample x_shoot_key into key_prev on every tick only; a fire request exists when x_shoot_key = 1 and key_prev = 0 at a tick.
REQ-015 SHALL spawn a shot when a fire request exists, cooldown = 0, and at least one slot was inactive before the tick; the spawn uses the lowest-index inactive slot.
REQ-016 SHALL set spawn position as: y = Megaman_y_position + 26; for dir = 1, x = Megaman_x_position + 60; for dir = 0, x = Megaman_x_position - 8, clamped to 0 if Megaman_x_position < 8; dir = last_horizontal.
REQ-017 SHALL, on a spawn, load cooldown with COOLDOWN and assert shot_fire for the same single Clk; otherwise cooldown SHALL decrement by 1 per tick and saturate at 0.
REQ-018 SHALL move every already-active slot each tick by SHOT_SPEED: +SHOT_SPEED when dir = 1, -SHOT_SPEED when dir = 0; a slot does not move on the tick it spawns.
REQ-019 SHALL deactivate a right-moving slot instead of moving it when x + SHOT_SPEED + SHOT_W > 639, and a left-moving slot when x < SHOT_SPEED; edge comparisons use 11-bit arithmetic, so no wrap-around occurs.
REQ-020 SHALL NOT reuse a slot freed by a despawn until the next tick (allocation is based on pre-tick active flags).
REQ-021 SHALL, when all 3 slots are active, ignore a fire request: no spawn, no cooldown load, key_prev still updates, so the key must be released and pressed again.
REQ-022 SHALL drive is_shot combinationally = OR over active slots of (x <= DrawX <= x + SHOT_W - 1 and y <= DrawY <= y + SHOT_H - 1).
REQ-023 SHALL drive shot_active directly from the slot active flags, registered.

Reset
REQ-024 SHALL, while RESET = 1 at a Clk edge, clear all slots (active = 0, x = 0, y = 0, dir = 0), cooldown, key_prev, frame_clk_delayed, tick and shot_fire; RESET takes priority over a simultaneous tick.
REQ-025 SHALL, if RESET asserts mid-flight, discard all shots; the first spawn after RESET requires a fresh 0-to-1 key transition seen at a tick.

Verification
REQ-026 Megaman at (100,337), last_horizontal = 1, key pressed before a tick -> slot0 active at (160,363), shot_fire one Clk, shot_active = 001; next tick x = 166.
REQ-027 last_horizontal = 0, Megaman_x_position = 4, key press -> spawn x = 0, dir = 0; next tick slot deactivates, shot_active = 000, no underflow.
REQ-028 Right shot at x = 626 -> deactivated on the next tick (626+6+8 > 639); shot at x = 624 -> moves to 630, then deactivates on the following tick.
REQ-029 Key held high across 20 ticks -> exactly one spawn; press/release every 2 ticks -> spawns no closer than 8 ticks apart.
REQ-030 Three shots active plus a new press -> no spawn, cooldown unchanged; a tick that despawns slot1 while a press is pending -> no spawn that tick, slot1 spawns on the next valid press.
REQ-031 RESET with 2 shots active -> shot_active = 000, is_shot = 0 at every DrawX/DrawY, cooldown = 0 on the next Clk.
